// File: rtl/alu_operand_stage.sv
`timescale 1ns / 1ps
// alu_operand_stage
// ID/EX pipeline register in front of the add-based ALU. Resolves EX/MEM
// forwarding and load-use stalls on the decoded op, pre-conditions add2
// (negation for SUB, shift-amount masking for shifts) and holds the result
// behind a valid/ready handshake. One cycle of latency.
//
// alu_sel encoding (shared with the alu block):
//   0 ADD  1 SUB  2 SLL  3 SLT  4 SLTU  5 XOR  6 SRL  7 SRA  8 OR  9 AND
//   Any other code is carried through untouched.

module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [3:0]      id_alu_sel,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic [4:0]      id_rd_addr,

    input  logic            ex_fwd_we,
    input  logic            ex_fwd_is_load,
    input  logic [4:0]      ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_we,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] add1,
    output logic [XLEN-1:0] add2,
    output logic [3:0]      alu_sel,
    output logic [4:0]      ex_rd_addr
);

    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] add2_cond;
    logic            hazard;
    logic            capture;

    logic            ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0] add1_q,       add1_d;
    logic [XLEN-1:0] add2_q,       add2_d;
    logic [3:0]      alu_sel_q,    alu_sel_d;
    logic [4:0]      ex_rd_addr_q, ex_rd_addr_d;

    // Per-source bypass: the younger EX result beats MEM; x0 always reads the register file.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fwd_rs1 = id_rs1_data;
        fwd_rs2 = id_rs2_data;

        if (ex_fwd_we && (ex_fwd_rd == id_rs1_addr) && (id_rs1_addr != 5'd0)) begin
            fwd_rs1 = ex_fwd_data;
        end else if (mem_fwd_we && (mem_fwd_rd == id_rs1_addr) && (id_rs1_addr != 5'd0)) begin
            fwd_rs1 = mem_fwd_data;
        end

        if (ex_fwd_we && (ex_fwd_rd == id_rs2_addr) && (id_rs2_addr != 5'd0)) begin
            fwd_rs2 = ex_fwd_data;
        end else if (mem_fwd_we && (mem_fwd_rd == id_rs2_addr) && (id_rs2_addr != 5'd0)) begin
            fwd_rs2 = mem_fwd_data;
        end
    end

    // Load-use detection and upstream ready: a load in EX has no data yet, so a dependent op waits.
    always_comb begin
        hazard = id_valid && ex_fwd_we && ex_fwd_is_load && (ex_fwd_rd != 5'd0) &&
                 ((!id_use_pc  && (ex_fwd_rd == id_rs1_addr)) ||
                  (!id_use_imm && (ex_fwd_rd == id_rs2_addr)));
        id_ready = !hazard && (!ex_valid_q || ex_ready);
        capture  = id_valid && id_ready;
    end

    // Operand selection and add2 conditioning for the ALU's single adder / shifter.
    always_comb begin
        op1 = id_use_pc  ? id_pc  : fwd_rs1;
        op2 = id_use_imm ? id_imm : fwd_rs2;

        case (id_alu_sel)
            ALU_SUB:                   add2_cond = ~op2 + ONE;
            ALU_SLL, ALU_SRL, ALU_SRA: add2_cond = {{(XLEN-SHW){1'b0}}, op2[SHW-1:0]};
            default:                   add2_cond = op2;
        endcase
    end

    // Next-state: flush kills the valid bit only, capture loads everything, consume drops valid.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        add1_d       = add1_q;
        add2_d       = add2_q;
        alu_sel_d    = alu_sel_q;
        ex_rd_addr_d = ex_rd_addr_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (capture) begin
            ex_valid_d   = 1'b1;
            add1_d       = op1;
            add2_d       = add2_cond;
            alu_sel_d    = id_alu_sel;
            ex_rd_addr_d = id_rd_addr;
        end else if (ex_ready && ex_valid_q) begin
            ex_valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            ex_valid_q   <= 1'b0;
            add1_q       <= '0;
            add2_q       <= '0;
            alu_sel_q    <= 4'd0;
            ex_rd_addr_q <= 5'd0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            add1_q       <= add1_d;
            add2_q       <= add2_d;
            alu_sel_q    <= alu_sel_d;
            ex_rd_addr_q <= ex_rd_addr_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign add1       = add1_q;
    assign add2       = add2_q;
    assign alu_sel    = alu_sel_q;
    assign ex_rd_addr = ex_rd_addr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
`timescale 1ns / 1ps
// Scoreboard bench for alu_operand_stage: the driver predicts each accepted
// op from the operand rules and queues it; the monitor compares whatever the
// stage presents against the head of that queue.

module tb_alu_operand_stage;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [3:0]      id_alu_sel;
    logic [4:0]      id_rs1_addr, id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data;
    logic [XLEN-1:0] id_imm, id_pc;
    logic            id_use_imm, id_use_pc;
    logic [4:0]      id_rd_addr;
    logic            ex_fwd_we, ex_fwd_is_load;
    logic [4:0]      ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            mem_fwd_we;
    logic [4:0]      mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] add1, add2;
    logic [3:0]      alu_sel;
    logic [4:0]      ex_rd_addr;

    alu_operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_alu_sel(id_alu_sel),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
        .id_rd_addr(id_rd_addr),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_is_load(ex_fwd_is_load), .ex_fwd_rd(ex_fwd_rd),
        .ex_fwd_data(ex_fwd_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .add1(add1), .add2(add2), .alu_sel(alu_sel), .ex_rd_addr(ex_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] a1;
        logic [XLEN-1:0] a2;
        logic [3:0]      sel;
        logic [4:0]      rd;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mdl_valid = 1'b0;
    bit   rst_prev  = 1'b1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference value of a source register after bypassing.
    function automatic logic [XLEN-1:0] src_value(input logic [4:0] a, input logic [XLEN-1:0] rf);
        if (a == 5'd0)                      return rf;
        if (ex_fwd_we && ex_fwd_rd == a)    return ex_fwd_data;
        if (mem_fwd_we && mem_fwd_rd == a)  return mem_fwd_data;
        return rf;
    endfunction

    function automatic bit model_hazard();
        if (!(id_valid && ex_fwd_we && ex_fwd_is_load) || ex_fwd_rd == 5'd0) return 1'b0;
        return (!id_use_pc && ex_fwd_rd == id_rs1_addr) || (!id_use_imm && ex_fwd_rd == id_rs2_addr);
    endfunction

    function automatic exp_t model_op();
        exp_t e;
        logic [XLEN-1:0] o2;
        e.a1 = id_use_pc ? id_pc : src_value(id_rs1_addr, id_rs1_data);
        o2   = id_use_imm ? id_imm : src_value(id_rs2_addr, id_rs2_data);
        if (id_alu_sel == ALU_SUB)
            e.a2 = 32'd0 - o2;
        else if (id_alu_sel == ALU_SLL || id_alu_sel == ALU_SRL || id_alu_sel == ALU_SRA)
            e.a2 = o2 % XLEN;
        else
            e.a2 = o2;
        e.sel = id_alu_sel;
        e.rd  = id_rd_addr;
        return e;
    endfunction

    // Monitor: mid-cycle, compare the presented op with the head of the scoreboard; pop on consume.
    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_op: ex_valid=1 but no op expected at %0t", $time);
            end else begin
                check("add1",       add1,              sb_q[0].a1);
                check("add2",       add2,              sb_q[0].a2);
                check("alu_sel",    {28'd0, alu_sel},  {28'd0, sb_q[0].sel});
                check("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, sb_q[0].rd});
                if (ex_ready) void'(sb_q.pop_front());
            end
        end
    end

    // One cycle: inputs were set just after the last edge; predict this edge, then advance.
    task automatic step();
        bit rdy;
        #6;
        if (rst_prev) begin
            check("rst_add1",  add1,                 '0);
            check("rst_add2",  add2,                 '0);
            check("rst_sel",   {28'd0, alu_sel},     '0);
            check("rst_rd",    {27'd0, ex_rd_addr},  '0);
        end
        check("ex_valid", {31'd0, ex_valid}, {31'd0, mdl_valid});
        rdy = !model_hazard() && (!mdl_valid || ex_ready);
        check("id_ready", {31'd0, id_ready}, {31'd0, rdy});
        if (rst || flush) begin
            sb_q.delete();
            mdl_valid = 1'b0;
        end else if (id_valid && rdy) begin
            sb_q.push_back(model_op());
            mdl_valid = 1'b1;
        end else if (ex_ready) begin
            mdl_valid = 1'b0;
        end
        rst_prev = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] sel,
                          input logic [4:0] r1a, input logic [XLEN-1:0] r1d,
                          input logic [4:0] r2a, input logic [XLEN-1:0] r2d,
                          input logic [4:0] rd);
        id_valid    = 1'b1;
        id_alu_sel  = sel;
        id_rs1_addr = r1a;
        id_rs1_data = r1d;
        id_rs2_addr = r2a;
        id_rs2_data = r2d;
        id_rd_addr  = rd;
        id_use_imm  = 1'b0;
        id_use_pc   = 1'b0;
    endtask

    task automatic clear_fwd();
        ex_fwd_we      = 1'b0;
        ex_fwd_is_load = 1'b0;
        ex_fwd_rd      = 5'd0;
        ex_fwd_data    = '0;
        mem_fwd_we     = 1'b0;
        mem_fwd_rd     = 5'd0;
        mem_fwd_data   = '0;
    endtask

    task automatic randomize_inputs();
        rst            = ($urandom_range(0, 49) == 0);
        flush          = ($urandom_range(0, 19) == 0);
        id_valid       = ($urandom_range(0, 4) != 0);
        ex_ready       = ($urandom_range(0, 9) < 7);
        id_alu_sel     = 4'($urandom_range(0, 15));
        id_rs1_addr    = 5'($urandom_range(0, 7));
        id_rs2_addr    = 5'($urandom_range(0, 7));
        id_rs1_data    = $urandom;
        id_rs2_data    = $urandom;
        id_imm         = $urandom;
        id_pc          = $urandom;
        id_use_imm     = ($urandom_range(0, 3) == 0);
        id_use_pc      = ($urandom_range(0, 3) == 0);
        id_rd_addr     = 5'($urandom);
        ex_fwd_we      = ($urandom_range(0, 1) == 1);
        ex_fwd_is_load = ($urandom_range(0, 2) == 0);
        ex_fwd_rd      = 5'($urandom_range(0, 7));
        ex_fwd_data    = $urandom;
        mem_fwd_we     = ($urandom_range(0, 1) == 1);
        mem_fwd_rd     = 5'($urandom_range(0, 7));
        mem_fwd_data   = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        set_op(ALU_ADD, 5'd0, '0, 5'd0, '0, 5'd0);
        id_valid = 1'b0;
        id_imm = '0;
        id_pc = '0;
        clear_fwd();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back ADDs, then one idle cycle.
        set_op(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);            step();
        set_op(ALU_ADD, 5'd8, 32'd100, 5'd9, 32'd23, 5'd10);        step();
        id_valid = 1'b0;                                             step();

        // SUB negation, SUB of zero, shift-amount masking.
        set_op(ALU_SUB, 5'd1, 32'd10, 5'd2, 32'd3, 5'd5);           step();
        set_op(ALU_SUB, 5'd1, 32'd10, 5'd2, 32'd0, 5'd5);           step();
        set_op(ALU_SLL, 5'd1, 32'd1, 5'd2, 32'h25, 5'd5);           step();
        set_op(ALU_ADD, 5'd0, '0, 5'd0, '0, 5'd7);
        id_use_pc = 1'b1; id_pc = 32'h1000;
        id_use_imm = 1'b1; id_imm = 32'hFFFF_FFF0;                   step();

        // EX beats MEM; x0 is never bypassed.
        ex_fwd_we = 1'b1; ex_fwd_rd = 5'd4; ex_fwd_data = 32'h11;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h22;
        set_op(ALU_ADD, 5'd4, 32'h99, 5'd0, 32'd1, 5'd1);           step();
        ex_fwd_rd = 5'd0; mem_fwd_rd = 5'd0;
        set_op(ALU_ADD, 5'd0, 32'h99, 5'd0, 32'd1, 5'd1);           step();
        clear_fwd();

        // Load-use: one stalled cycle, then the loaded value arrives via MEM.
        ex_fwd_we = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd6; ex_fwd_data = 32'hDEAD;
        set_op(ALU_ADD, 5'd1, 32'd2, 5'd6, 32'd0, 5'd9);            step();
        clear_fwd();
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'h66;
        step();
        clear_fwd();
        id_valid = 1'b0;                                             step();

        // Stall three cycles with a new op waiting, then flush.
        set_op(ALU_SRA, 5'd3, 32'h8000_0000, 5'd4, 32'h3F, 5'd12); step();
        ex_ready = 1'b0;
        set_op(ALU_XOR_CODE(), 5'd1, 32'd1, 5'd2, 32'd2, 5'd13);
        repeat (3) step();
        flush = 1'b1;                                                step();
        flush = 1'b0; id_valid = 1'b0;                               step();
        ex_ready = 1'b1;

        // Reset while an op is held.
        set_op(ALU_ADD, 5'd1, 32'h1234, 5'd2, 32'h5678, 5'd15);     step();
        ex_ready = 1'b0; id_valid = 1'b0;                            step();
        rst = 1'b1;                                                  step();
        rst = 1'b0; ex_ready = 1'b1;                                 step();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            step();
        end

        // Drain and confirm nothing predicted was left unpresented.
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        clear_fwd();
        repeat (3) step();
        check("drain_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [3:0] ALU_XOR_CODE();
        return 4'd5;
    endfunction

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that feeds the `alu` block: registers decoded operands and `alu_sel` behind a valid/ready handshake and resolves EX/MEM forwarding and load-use hazards. It also pre-conditions operands for the ALU's fixed add-based datapath.
- SUB: add2 is pre-negated.
- Shifts: add2 is masked to the legal shift amount.

Latency is one cycle; the registered outputs drive `alu` add1/add2/alu_sel directly.

## Interface
Parameters:
- XLEN, `XLEN from defines.v (32): datapath width
- SHW, $clog2(XLEN) (5): shift-amount width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the registered op (branch/trap redirect)
- id_valid  in  1  decoder presents an op
- id_ready  out  1  stage accepts op this cycle
- id_alu_sel  in  4  `ALU_* op code
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_pc  in  XLEN  instruction PC
- id_use_imm  in  1  add2 source is id_imm instead of rs2
- id_use_pc  in  1  add1 source is id_pc instead of rs1
- id_rd_addr  in  5  destination index, passed through
- ex_fwd_we, ex_fwd_is_load  in  1  EX-stage op writes rd; that op is a load
- ex_fwd_rd  in  5  EX-stage destination
- ex_fwd_data  in  XLEN  EX-stage result
- mem_fwd_we  in  1  MEM-stage op writes rd
- mem_fwd_rd  in  5  MEM-stage destination
- mem_fwd_data  in  XLEN  MEM-stage result
- ex_valid  out  1  registered op valid to ALU
- ex_ready  in  1  downstream consumes op
- add1, add2  out  XLEN  registered ALU operands
- alu_sel  out  4  registered ALU op
- ex_rd_addr  out  5  registered destination

## Operation
Forwarding is evaluated per source, combinationally on id_* at capture:
- EX match first: ex_fwd_we && ex_fwd_rd == src && src != 0 selects ex_fwd_data.
- Otherwise MEM match: mem_fwd_we && mem_fwd_rd == src && src != 0 selects mem_fwd_data.
- Otherwise register-file data is used.
- x0 is never forwarded.

Load-use hazard:
- hazard = id_valid && ex_fwd_we && ex_fwd_is_load && ex_fwd_rd != 0 && (ex_fwd_rd == id_rs1_addr when !id_use_pc, or ex_fwd_rd == id_rs2_addr when !id_use_imm).
- On hazard, id_ready = 0 and a bubble is inserted.

Operand formation:
- op1 = id_use_pc ? id_pc : fwd_rs1.
- op2 = id_use_imm ? id_imm : fwd_rs2.
- Conditioning applied to op2 to produce add2:
  - `ALU_SUB: add2 = ~op2 + 1, computed modulo 2^XLEN.
  - `ALU_SLL/`ALU_SRL/`ALU_SRA: add2 = {zeros, op2[SHW-1:0]}.
  - All other ops: add2 = op2.
- add1 = op1 unmodified. Unknown alu_sel passes through unchanged.

Handshake and register update:
- id_ready = !hazard && (!ex_valid || ex_ready).
- Register update priority per edge:
  1. rst: clear.
  2. flush: ex_valid <= 0; data registers keep their values.
  3. id_valid && id_ready: load all registers, ex_valid <= 1.
  4. ex_ready && ex_valid (no capture): ex_valid <= 0.
  5. Otherwise hold.
- While ex_valid && !ex_ready, add1/add2/alu_sel/ex_rd_addr are held stable.

## Timing
- Reset values: ex_valid=0, add1=0, add2=0, alu_sel=0, ex_rd_addr=0. id_ready evaluates to 1 after reset (no hazard).
- Latency: op captured at edge N is presented on outputs from N until consumed; throughput is one op/cycle with ex_ready held 1.
- Simultaneous consume and capture in the same cycle: new op replaces old; ex_valid stays 1.
- flush with id_valid && id_ready in the same cycle: flush wins, op dropped, ex_valid=0. Upstream must treat that op as consumed.
- flush during stall: ex_valid=0 next cycle and id_ready=1 (absent hazard).
- rst mid-stall: all outputs return to reset values next edge.
- Hazard persists for as long as the load stays in EX; it clears the cycle the load leaves (then MEM forwarding applies).
- Forwarding inputs are sampled only at the capture edge; held ops are not re-forwarded.

## Test plan
- Back-to-back ADD, ex_ready=1: rs1=5, rs2=7 -> add1=5, add2=7, alu_sel=`ALU_ADD` one cycle later; ex_valid stays 1 for consecutive ops.
- SUB rs1=10, rs2=3 -> add2=0xFFFFFFFD. SUB op2=0 -> add2=0. SLL rs2=0x25 -> add2=5.
- Forwarding: EX rd=4 data=0x11 and MEM rd=4 data=0x22, id_rs1=4 -> add1=0x11. Same match with rd=0 -> add1=register-file data.
- Load-use: ex_fwd_is_load, rd=6, id_rs2=6, id_use_imm=0 -> id_ready=0 for one cycle and ex_valid=0 bubble. Next cycle MEM match forwards the value.
- Stall then flush: ex_ready=0 for 3 cycles -> outputs stable and id_ready=0. Assert flush -> ex_valid=0 next cycle and id_ready=1.
- rst asserted while ex_valid=1 -> next cycle all outputs zero.
